// File: rtl/io_bus_controller.sv
// I/O-space bus sequencer: turns a CPU IORead/IOWrite into a held request on a
// one-hot device select, waits for that device's ack or a timeout, and stalls the CPU meanwhile.
module io_bus_controller #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        IORead,
    input  logic        IOWrite,
    input  logic [9:0]  addr_low,
    input  logic [31:0] wdata,
    input  logic [3:0]  io_ack,
    input  logic [31:0] io_rdata,
    output logic        cpu_stall,
    output logic [31:0] rdata,
    output logic        io_err,
    output logic [3:0]  dev_sel,
    output logic [3:0]  io_addr,
    output logic [31:0] io_wdata,
    output logic        io_we,
    output logic        io_re
);

    typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

    typedef struct packed {
        logic [1:0] dev;
        logic       wr;
    } req_t;

    state_t      state_q, state_d;
    req_t        req_q, req_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic [3:0]  dev_sel_q, dev_sel_d;
    logic [3:0]  io_addr_q, io_addr_d;
    logic [31:0] io_wdata_q, io_wdata_d;
    logic        io_we_q, io_we_d;
    logic        io_re_q, io_re_d;
    logic        io_err_q, io_err_d;

    // Strobes are registered, so they are computed from the state being entered.
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        io_addr_d  = io_addr_q;
        io_wdata_d = io_wdata_q;
        dev_sel_d  = 4'b0000;
        io_we_d    = 1'b0;
        io_re_d    = 1'b0;
        io_err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (IORead || IOWrite) begin
                    req_d.dev  = addr_low[5:4];
                    req_d.wr   = IOWrite;
                    io_addr_d  = addr_low[3:0];
                    io_wdata_d = wdata;
                    cnt_d      = 8'd0;
                    dev_sel_d  = 4'b0001 << addr_low[5:4];
                    io_we_d    = IOWrite;
                    io_re_d    = !IOWrite;
                    state_d    = REQ;
                end
            end
            REQ: begin
                cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                // Ack is checked before the timeout so a last-cycle ack still completes.
                if (io_ack[req_q.dev]) begin
                    if (!req_q.wr) rdata_d = io_rdata;
                    state_d = DONE;
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    if (!req_q.wr) rdata_d = 32'h0000_0000;
                    io_err_d = 1'b1;
                    state_d  = ERR;
                end else begin
                    dev_sel_d = dev_sel_q;
                    io_we_d   = io_we_q;
                    io_re_d   = io_re_q;
                end
            end
            DONE, ERR: state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= IDLE;
            req_q      <= '0;
            cnt_q      <= 8'd0;
            rdata_q    <= 32'h0000_0000;
            dev_sel_q  <= 4'b0000;
            io_addr_q  <= 4'h0;
            io_wdata_q <= 32'h0000_0000;
            io_we_q    <= 1'b0;
            io_re_q    <= 1'b0;
            io_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            dev_sel_q  <= dev_sel_d;
            io_addr_q  <= io_addr_d;
            io_wdata_q <= io_wdata_d;
            io_we_q    <= io_we_d;
            io_re_q    <= io_re_d;
            io_err_q   <= io_err_d;
        end
    end

    // Combinational so the requesting instruction is frozen in the same cycle.
    assign cpu_stall = ((state_q == IDLE) && (IORead || IOWrite)) || (state_q == REQ);
    assign rdata     = rdata_q;
    assign io_err    = io_err_q;
    assign dev_sel   = dev_sel_q;
    assign io_addr   = io_addr_q;
    assign io_wdata  = io_wdata_q;
    assign io_we     = io_we_q;
    assign io_re     = io_re_q;

endmodule

// File: doc/io_bus_controller.md
# io_bus_controller

Sequences CPU I/O-space accesses (IORead/IOWrite from the control unit, address high bits all ones) onto a multi-cycle request/acknowledge peripheral bus. Decodes the low address bits into a one-hot device select, holds the request until the addressed device acknowledges or a timeout expires, and stalls the CPU for the duration. Sits between the control unit/ALU result and the peripherals (LED, switch, timer, UART); its read data feeds the memory-or-I/O write-back mux.

## Interface
- TIMEOUT, 15: max REQ cycles without ack before abort; legal range 2..255.

- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low
- IORead  in  1  I/O load this cycle (from control unit)
- IOWrite  in  1  I/O store this cycle (from control unit)
- addr_low  in  10  Alu_result[9:0]; [5:4] device index, [3:0] register offset
- wdata  in  32  store data (rt value)
- io_ack  in  4  per-device acknowledge, one bit per device
- io_rdata  in  32  shared peripheral read bus, valid with ack
- cpu_stall  out  1  freeze PC/pipeline this cycle
- rdata  out  32  read data to write-back mux
- io_err  out  1  one-cycle pulse on timeout
- dev_sel  out  4  one-hot device select
- io_addr  out  4  register offset to device
- io_wdata  out  32  write data to device
- io_we  out  1  write strobe
- io_re  out  1  read strobe

## Operation
- States: IDLE, REQ, DONE, ERR.
- IDLE: on IORead|IOWrite, latch dev = addr_low[5:4], io_addr = addr_low[3:0], wdata, direction (write if IOWrite; IOWrite wins if both high); clear counter; next REQ. Else stay.
- REQ: dev_sel = onehot(dev), io_we/io_re per latched direction, io_addr/io_wdata from latches, all stable for the whole state. Counter increments each cycle.
  - io_ack[dev]=1 -> on read, rdata <= io_rdata; next DONE.
  - no ack and counter == TIMEOUT-1 -> next ERR.
  - ack and timeout in same cycle: ack wins.
  - ack bits of non-selected devices ignored.
- DONE: strobes/dev_sel low, stall low; CPU completes the instruction this cycle. Next IDLE unconditionally (the still-asserted IORead/IOWrite of the completing instruction must not start a new access).
- ERR: as DONE, but io_err=1 and on read rdata <= 32'h0000_0000. Next IDLE.
- Writes leave rdata unchanged; rdata holds its value until the next completed read or ERR.
- cpu_stall = (IDLE & (IORead|IOWrite)) | REQ; combinational so the requesting cycle is frozen.
- Counter: 8 bits, saturates; only meaningful in REQ.

## Timing
- Reset (reset=0 at edge): state IDLE, counter 0, rdata 0, dev_sel 0, io_addr 0, io_wdata 0, io_we 0, io_re 0, io_err 0. cpu_stall then follows IDLE rule.
- Reset mid-access: abort at that edge; no DONE/ERR, no io_err pulse; strobes low the next cycle.
- All outputs except cpu_stall are registered.
- Ack in first REQ cycle: stall 2 cycles (request cycle + REQ), DONE in cycle 3, rdata valid in DONE.
- Ack after k REQ cycles (k ≥ 1): stall k+1 cycles.
- No ack: exactly TIMEOUT REQ cycles, ERR in the following cycle; stall TIMEOUT+1 cycles.
- Back-to-back I/O instructions: the second one is seen in IDLE the cycle after DONE/ERR; minimum spacing 3 cycles per access.

## Test plan
- Reset: hold reset=0 two cycles with IORead=1 -> all registered outputs 0, state IDLE; after release, stall asserts combinationally.
- Read with immediate ack: IORead, addr_low=10'h060 (dev 2, off 0), device 2 acks in first REQ cycle with io_rdata=32'h0000_00A5 -> dev_sel=4'b0100, io_re=1 one cycle, stall 2 cycles, rdata=32'hA5 in DONE.
- Write with delayed ack: IOWrite, addr_low=10'h013, wdata=32'h1234_5678, ack after 4 REQ cycles -> dev_sel=4'b0010, io_addr=4'h3, io_we held 4 cycles, stall 5 cycles, rdata unchanged.
- Timeout: TIMEOUT=15, IORead dev 3, no ack; wrong-device ack io_ack=4'b0001 pulsed mid-way -> ignored, 15 REQ cycles, io_err one-cycle pulse, rdata=0, stall 16 cycles.
- Ack on last timeout cycle: ack at counter 14 -> DONE, io_err stays 0.
- Reset mid-REQ, then IOWrite and IORead both high -> abort without io_err; after reset a write (io_we=1, io_re=0) is issued.
